matmul_out_framer: RTL

Downstream stage of the matrix-multiply accelerator. Consumes the 16-word result stream the multiplier emits (which carries no usable end-of-frame marker), buffers it in a small FIFO, and re-emits it as a properly framed AXI-Stream toward the DMA with `m_tlast` on the final beat. Also pulses a frame-done event and counts completed frames for the CPU-side status path.

---
 rtl/matmul_pkg.sv | 13 +
 rtl/matmul_out_framer_if.sv | 23 ++
 rtl/stream_fifo.sv | 51 +++++
 rtl/matmul_out_framer.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared state encoding and sizing for the matmul output framer
package matmul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_SUM  = 2'd2
  } frame_state_t;

  localparam int MATMUL_FRAME_LEN = 16;
  localparam int MATMUL_DATA_W    = 32;

endpackage

// File: rtl/matmul_out_framer_if.sv
// rtl/matmul_out_framer_if.sv - result-in / framed-out stream bundle for the matmul output framer
interface matmul_out_framer_if #(
  parameter int pDATA_WIDTH = 32
);
  logic                   s_tvalid;
  logic [pDATA_WIDTH-1:0] s_tdata;
  logic                   s_tready;
  logic                   m_tvalid;
  logic [pDATA_WIDTH-1:0] m_tdata;
  logic                   m_tlast;
  logic                   m_tready;

  // slave: the framer itself; master: the multiplier/DMA side driving it
  modport slave (
    input  s_tvalid, s_tdata, m_tready,
    output s_tready, m_tvalid, m_tdata, m_tlast
  );

  modport master (
    output s_tvalid, s_tdata, m_tready,
    input  s_tready, m_tvalid, m_tdata, m_tlast
  );
endinterface

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - first-word-fall-through FIFO with flush; pointers carry an extra wrap bit
module stream_fifo #(
  parameter int pWIDTH = 32,
  parameter int pDEPTH = 4,
  localparam int AW    = $clog2(pDEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [pWIDTH-1:0] wdata,
  output logic [pWIDTH-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count
);

  logic [pWIDTH-1:0] mem [pDEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // storage needs no reset; the framer never exposes an unwritten slot
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/matmul_out_framer.sv
// rtl/matmul_out_framer.sv - frames the 16-word result stream with tlast; MATMUL_OUT_CHECKSUM_EN appends an XOR checksum beat
module matmul_out_framer
  import matmul_pkg::*;
#(
  parameter int pDATA_WIDTH = MATMUL_DATA_W,
  parameter int pFRAME_LEN  = MATMUL_FRAME_LEN,
  parameter int pFIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  matmul_out_framer_if.slave  sif,
  output logic                frame_done,
  output logic [15:0]         frame_cnt,
  output logic                busy
);

  localparam int IW = $clog2(pFRAME_LEN) + 1;
  localparam int CW = $clog2(pFIFO_DEPTH) + 1;

  frame_state_t           state_q;
  logic [IW-1:0]          idx_q;
  logic [15:0]            frame_cnt_q;
  logic                   rdy_q;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [pDATA_WIDTH-1:0] fifo_head;
  logic [CW-1:0]          fifo_count;
  logic [CW-1:0]          occ_next;
  logic                   push;
  logic                   pop;
  logic                   beat;
  logic                   in_data;
  logic                   last_idx;
  logic                   frame_end;
  logic                   next_active;
`ifdef MATMUL_OUT_CHECKSUM_EN
  logic [pDATA_WIDTH-1:0] csum_q;
`endif

  // rdy_q keeps s_tready low while reset is held and releases it one edge later
  assign sif.s_tready = rdy_q && !fifo_full && !clear;
  assign push         = sif.s_tvalid && sif.s_tready;
  assign in_data      = (state_q != ST_SUM);
  assign last_idx     = (idx_q == IW'(pFRAME_LEN - 1));
  assign beat         = sif.m_tvalid && sif.m_tready && !clear;
  assign pop          = beat && in_data;

`ifdef MATMUL_OUT_CHECKSUM_EN
  assign sif.m_tvalid = in_data ? !fifo_empty : 1'b1;
  assign sif.m_tdata  = !in_data ? csum_q : (fifo_empty ? '0 : fifo_head);
  assign sif.m_tlast  = !in_data;
  assign frame_end    = beat && !in_data;
`else
  assign sif.m_tvalid = !fifo_empty;
  assign sif.m_tdata  = fifo_empty ? '0 : fifo_head;
  assign sif.m_tlast  = !fifo_empty && last_idx;
  assign frame_end    = beat && last_idx;
`endif

  // IDLE with a waiting word leaves on its own; otherwise only a frame end returns to IDLE
  assign next_active = (state_q == ST_IDLE && !beat) ? !fifo_empty : !frame_end;
  assign occ_next    = fifo_count + CW'(push) - CW'(pop);
  assign frame_cnt   = frame_cnt_q;

  stream_fifo #(
    .pWIDTH (pDATA_WIDTH),
    .pDEPTH (pFIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (clear),
    .push  (push),
    .pop   (pop),
    .wdata (sif.s_tdata),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q       <= 1'b0;
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      frame_done  <= 1'b0;
      frame_cnt_q <= '0;
      busy        <= 1'b0;
`ifdef MATMUL_OUT_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      rdy_q <= 1'b1;
      if (clear) begin
        state_q    <= ST_IDLE;
        idx_q      <= '0;
        frame_done <= 1'b0;
        busy       <= 1'b0;
`ifdef MATMUL_OUT_CHECKSUM_EN
        csum_q     <= '0;
`endif
      end else begin
        frame_done <= frame_end;
        busy       <= next_active || (occ_next != '0);
        if (frame_end) frame_cnt_q <= frame_cnt_q + 16'd1;
        case (state_q)
          ST_IDLE, ST_DATA: begin
            if (beat) begin
`ifdef MATMUL_OUT_CHECKSUM_EN
              csum_q <= csum_q ^ fifo_head;
`endif
              if (last_idx) begin
                idx_q <= '0;
`ifdef MATMUL_OUT_CHECKSUM_EN
                state_q <= ST_SUM;
`else
                state_q <= ST_IDLE;
`endif
              end else begin
                idx_q   <= idx_q + IW'(1);
                state_q <= ST_DATA;
              end
            end else if (!fifo_empty) begin
              state_q <= ST_DATA;
            end
          end
          ST_SUM: begin
            if (beat) begin
              state_q <= ST_IDLE;
`ifdef MATMUL_OUT_CHECKSUM_EN
              csum_q  <= '0;
`endif
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
